// File: rtl/sram_controller_pkg.sv
// Shared types and defaults for the MEM-stage SRAM controller.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOW  = 2'd1,
    S_HIGH = 2'd2,
    S_DONE = 2'd3
  } sram_state_e;

  localparam int unsigned DEF_BASE_ADDR   = 1024;
  localparam int unsigned DEF_WAIT_CYCLES = 2;

endpackage

// File: rtl/sram_controller.sv
// Splits each 32-bit LDR/STR into two 16-bit async-SRAM accesses of WAIT_CYCLES each.
// Request seen in IDLE -> DONE after 2*WAIT_CYCLES+1 cycles; ready low freezes the pipeline meanwhile.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
  parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  inout  wire  [15:0] SRAM_DQ,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N
);

  localparam int CW = $clog2(WAIT_CYCLES + 1);

  sram_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          wr_q, wr_d;
  logic [16:0]   idx_q, idx_d;
  logic [31:0]   wdat_q, wdat_d;
  logic [31:0]   rdat_q, rdat_d;
  logic [17:0]   addr_q, addr_d;
  logic [16:0]   req_idx;
  logic          req;
  logic          last;

  // Offsets below BASE_ADDR wrap naturally through the 17-bit truncation.
  assign req_idx = 17'((address - 32'(BASE_ADDR)) >> 2);
  assign req     = wr_en | rd_en;
  assign last    = (cnt_q == CW'(WAIT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    addr_d  = addr_q;
    ready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = ~req;
        if (req) begin
          state_d = S_LOW;
          cnt_d   = '0;
          wr_d    = wr_en;
          idx_d   = req_idx;
          wdat_d  = write_data;
          addr_d  = {req_idx, 1'b0};
        end
      end
      S_LOW: begin
        if (last) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          addr_d  = {idx_q, 1'b1};
          if (!wr_q) rdat_d[15:0] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HIGH: begin
        if (last) begin
          state_d = S_DONE;
          if (!wr_q) rdat_d[31:16] = SRAM_DQ;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      addr_q  <= addr_d;
    end
  end

  assign SRAM_DQ = (wr_q && state_q == S_LOW)  ? wdat_q[15:0]  :
                   (wr_q && state_q == S_HIGH) ? wdat_q[31:16] : 16'hzzzz;

  assign SRAM_WE_N = ~(wr_q && (state_q == S_LOW || state_q == S_HIGH));
  assign SRAM_ADDR = addr_q;
  assign read_data = rdat_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized bench for sram_controller against a word-level memory model and a half-word SRAM model.
module tb_sram_controller;

  localparam int unsigned BASE = 1024;
  localparam int          W    = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_ub_n, sram_lb_n, sram_ce_n, sram_oe_n;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] sram_mem [0:262143];
  logic [31:0] ref_mem [int];
  logic [31:0] exp_rd;

  always #5 clk = ~clk;

  sram_controller #(.BASE_ADDR(BASE), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .address(address), .write_data(write_data),
    .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n),
    .SRAM_UB_N(sram_ub_n), .SRAM_LB_N(sram_lb_n),
    .SRAM_CE_N(sram_ce_n), .SRAM_OE_N(sram_oe_n)
  );

  // Asynchronous SRAM: drives the bus whenever it is not being written.
  assign sram_dq = sram_we_n ? sram_mem[sram_addr] : 16'hzzzz;

  always @(negedge clk) begin
    if (!sram_we_n) sram_mem[sram_addr] <= sram_dq;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = (a - BASE) / 4;
    return int'(off % 131072);
  endfunction

  function automatic logic [31:0] ref_read(input int ix);
    if (ref_mem.exists(ix)) return ref_mem[ix];
    return 32'h0;
  endfunction

  // One full access starting at cycle 0; returns just after the edge ending DONE.
  task automatic access(input bit wr, input bit rd, input logic [31:0] a,
                        input logic [31:0] d, input bit noisy);
    int          ix;
    bit          is_wr;
    logic [31:0] word;
    is_wr = wr;
    ix    = word_of(a);
    wr_en = wr; rd_en = rd; address = a; write_data = d;
    @(negedge clk);
    check("ready_cycle0", 32'(ready), 32'd0);
    for (int c = 1; c <= 2*W + 1; c++) begin
      @(posedge clk); #1;
      if (noisy) begin
        address    = $urandom;
        write_data = $urandom;
        wr_en      = 1'($urandom_range(0, 1));
        rd_en      = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (c <= 2*W) begin
        check("ready_busy", 32'(ready), 32'd0);
        check("sram_addr", 32'(sram_addr), 32'(ix * 2 + ((c > W) ? 1 : 0)));
        check("we_n_busy", 32'(sram_we_n), is_wr ? 32'd0 : 32'd1);
        if (is_wr) check("dq_write", 32'(sram_dq), (c > W) ? 32'(d[31:16]) : 32'(d[15:0]));
      end else begin
        if (is_wr) ref_mem[ix] = d;
        else       exp_rd = ref_read(ix);
        check("ready_done", 32'(ready), 32'd1);
        check("we_n_done", 32'(sram_we_n), 32'd1);
        check("read_data", read_data, exp_rd);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    wr_en = 1'b0; rd_en = 1'b0;
    address = $urandom; write_data = $urandom;
    @(negedge clk);
    check("ready_idle", 32'(ready), 32'd1);
    check("we_n_idle", 32'(sram_we_n), 32'd1);
    check("read_data_idle", read_data, exp_rd);
    @(posedge clk); #1;
  endtask

  initial begin
    int          ix;
    logic [31:0] a, d;
    bit          w, r;
    for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
    exp_rd = 32'h0;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b1; address = 32'h0; write_data = 32'h0;
    #3;
    check("rst_ready_req", 32'(ready), 32'd0);
    rd_en = 1'b0;
    #1;
    check("rst_ready_noreq", 32'(ready), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_read_data", read_data, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed: STR then back-to-back LDR at 1028, then write-wins at wrapped 1020.
    access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);
    access(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
    check("ldr_1028", read_data, 32'hDEADBEEF);
    check("sram_word2", 32'(sram_mem[2]), 32'h0000BEEF);
    check("sram_word3", 32'(sram_mem[3]), 32'h0000DEAD);
    access(1'b1, 1'b1, 32'd1020, 32'hCAFEF00D, 1'b1);
    check("wrap_low", 32'(sram_mem[18'h3FFFE]), 32'h0000F00D);
    check("wrap_high", 32'(sram_mem[18'h3FFFF]), 32'h0000CAFE);
    idle_cycle();
    access(1'b0, 1'b1, 32'd1020, 32'h0, 1'b1);
    check("ldr_wrap", read_data, 32'hCAFEF00D);

    // Random mix of reads/writes, noisy inputs and idle gaps.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = BASE + 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(0, 3));
      d = $urandom;
      w = 1'($urandom_range(0, 1));
      r = w ? 1'($urandom_range(0, 1)) : 1'b1;
      access(w, r, a, d, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // Reset during the HIGH half of a write aborts it asynchronously.
    a = BASE + 32'd40;
    d = 32'h12345678;
    ix = word_of(a);
    wr_en = 1'b1; rd_en = 1'b0; address = a; write_data = d;
    repeat (W + 1) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_we_n", 32'(sram_we_n), 32'd1);
    check("abort_addr", 32'(sram_addr), 32'd0);
    check("abort_read_data", read_data, 32'd0);
    check("abort_ready_req", 32'(ready), 32'd0);
    wr_en = 1'b0;
    #1;
    check("abort_ready_idle", 32'(ready), 32'd1);
    exp_rd = 32'h0;
    ref_mem[ix] = {ref_read(ix) >> 16, d[15:0]};
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    idle_cycle();
    access(1'b0, 1'b1, a, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got %0d expected %0d", 0, 1);
    $fatal(1);
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Data-memory controller in the MEM stage, directly downstream of the ALU. It takes the ALU result as a byte address for LDR/STR, plus the store data, and performs each 32-bit access as two 16-bit transactions on an external asynchronous SRAM. It deasserts `ready` to freeze the pipeline until the access completes.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `WAIT_CYCLES`, default 2: clock cycles spent on each 16-bit half access (≥1).

Ports:
- `clk`  in  1  system clock; one clock domain, rising-edge only.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_en`  in  1  STR request from the EXE/MEM register.
- `rd_en`  in  1  LDR request from the EXE/MEM register.
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (Rm value).
- `read_data`  out  32  load result, registered.
- `ready`  out  1  0 = freeze the pipeline.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  18  SRAM half-word address.
- `SRAM_WE_N`  out  1  write enable, active-low.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N`  out  1 each  tied to 0.

## Operation
- Word index: idx = (address − BASE_ADDR) >> 2, truncated to 17 bits. Addresses below BASE_ADDR or beyond 2^17 words wrap modulo 2^17. Address bits [1:0] are ignored.
- Low half uses SRAM_ADDR = {idx, 1'b0} with data bits [15:0]. High half uses {idx, 1'b1} with data bits [31:16].
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if wr_en|rd_en, latch command, idx and write_data, clear the wait counter, go to LOW. Otherwise stay in IDLE.
  - LOW: count WAIT_CYCLES cycles, then go to HIGH and clear the counter.
  - HIGH: count WAIT_CYCLES cycles, then go to DONE.
  - DONE: go to IDLE unconditionally.
- `ready`, combinational:
  - IDLE: ready = ~(wr_en|rd_en).
  - LOW and HIGH: ready = 0.
  - DONE: ready = 1.
- Write transaction:
  - SRAM_WE_N = 0 throughout LOW and HIGH, and 1 in every other state.
  - SRAM_DQ drives the latched low half in LOW and the high half in HIGH.
  - SRAM_DQ is high-Z in all other states and during reads.
- Read transaction:
  - read_data[15:0] is captured from SRAM_DQ on the last LOW cycle.
  - read_data[31:16] is captured on the last HIGH cycle.
  - read_data holds its value until the next read overwrites it; writes never change it.
- Simultaneous wr_en and rd_en: the write wins.
- Inputs that change or drop mid-transaction are ignored, because the access uses latched values.
- In DONE the request is still present but does not restart the FSM. A request present in the following IDLE cycle starts a new access, so back-to-back LDR/STR is supported.

## Timing
- Reset (async, any state) forces:
  - state = IDLE, wait counter = 0, read_data = 0;
  - SRAM_WE_N = 1, SRAM_DQ = Z, SRAM_ADDR = 0;
  - ready = ~(wr_en|rd_en).
- A request is first seen at cycle 0, in IDLE with ready = 0.
  - LOW occupies cycles 1..W and HIGH occupies cycles W+1..2W.
  - DONE is cycle 2W+1, with ready = 1.
  - With W = 2, the pipeline is frozen for 5 cycles and advances on the edge ending cycle 5.
- A new request can be accepted no earlier than cycle 2W+2.
- Reset asserted during LOW/HIGH aborts the access; a partially written word is acceptable.
- SRAM_ADDR is registered and stable for the whole duration of each half.

## Structure
- The shared package holds the FSM state enum (IDLE, LOW, HIGH, DONE) and the default BASE_ADDR and WAIT_CYCLES constants.
- Single module, no sub-module; the wait counter is inline, $clog2(WAIT_CYCLES+1) bits wide.
- The tri-state SRAM_DQ uses one continuous assign gated by state and the latched command.

## Test plan
- Reset mid-write (assert rst during HIGH) → SRAM_WE_N = 1, SRAM_DQ = Z, state IDLE, read_data = 0 immediately, without waiting for a clock.
- STR with address = 1028, write_data = 0xDEADBEEF, W = 2 → SRAM_ADDR = 2 with DQ = 0xBEEF for 2 cycles, then SRAM_ADDR = 3 with DQ = 0xDEAD for 2 cycles; ready = 0 for cycles 0–4 and 1 at cycle 5.
- LDR address = 1028 with an SRAM model holding [2] = 0xBEEF, [3] = 0xDEAD → read_data = 0xDEADBEEF valid at cycle 5; WE_N stays 1; DQ is never driven by the DUT.
- Back-to-back STR then LDR to the same address (1028) → the second access starts at cycle 6 and returns the value just written.
- wr_en = rd_en = 1 with address = 1020 → treated as a write to wrapped index 0x1FFFF: SRAM_ADDR = 0x3FFFE then 0x3FFFF; read_data unchanged.
- Inputs toggled during LOW/HIGH (address and data changed) → the transaction uses the latched values, and no extra access starts in DONE.
